// File: rtl/tc_sram_banked.sv
// ----------------------------------------------------------------------------
// tc_sram_banked
//
// Purpose:
//   Multi-port functional SRAM built from NumBanks single-ported banks. Words
//   are interleaved across banks by the low address bits. Each bank has its
//   own round-robin arbiter, so ports that target different banks are served
//   in the same cycle. Read data comes back after a fixed Latency with a
//   one-cycle valid strobe per accepted read.
//
// Optional feature (macro TC_SRAM_BANKED_PARITY_EN):
//   Each stored byte carries an even-parity bit. The extra output rerr_o
//   flags a parity mismatch on the returned read data and is aligned with
//   rvalid_o. If the macro is undefined there is no parity storage and no
//   rerr_o port.
//
// Ports:
//   clk_i     in   1                       clock
//   rst_ni    in   1                       asynchronous reset, active low
//   req_i     in   NumPorts                per-port request
//   gnt_o     out  NumPorts                per-port grant (combinational)
//   we_i      in   NumPorts                per-port write enable (1 = write)
//   addr_i    in   NumPorts x AddrWidth    per-port word address
//   wdata_i   in   NumPorts x DataWidth    per-port write data
//   be_i      in   NumPorts x BeWidth      per-port byte enables
//   rvalid_o  out  NumPorts                per-port read-data valid
//   rdata_o   out  NumPorts x DataWidth    per-port read data (held when idle)
//   rerr_o    out  NumPorts                parity error (macro builds only)
//
// Handshake: a request is accepted in any cycle where req_i[i] && gnt_o[i].
// A requestor that is not granted keeps req/we/addr/wdata/be stable until it
// is granted. gnt_o never depends on the requestor dropping req_i.
// ----------------------------------------------------------------------------
module tc_sram_banked #(
   parameter int unsigned NumPorts     = 4,
   parameter int unsigned NumBanks     = 4,
   parameter int unsigned WordsPerBank = 256,
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned ByteWidth    = 8,
   parameter int unsigned Latency      = 1,
   parameter int unsigned AddrWidth    = $clog2(NumBanks * WordsPerBank),
   parameter int unsigned BeWidth      = (DataWidth + ByteWidth - 1) / ByteWidth
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic [NumPorts-1:0]                  req_i,
   output logic [NumPorts-1:0]                  gnt_o,
   input  logic [NumPorts-1:0]                  we_i,
   input  logic [NumPorts-1:0][AddrWidth-1:0]   addr_i,
   input  logic [NumPorts-1:0][DataWidth-1:0]   wdata_i,
   input  logic [NumPorts-1:0][BeWidth-1:0]     be_i,
   output logic [NumPorts-1:0]                  rvalid_o,
   output logic [NumPorts-1:0][DataWidth-1:0]   rdata_o
`ifdef TC_SRAM_BANKED_PARITY_EN
   ,
   output logic [NumPorts-1:0]                  rerr_o
`endif
);

   localparam int unsigned Log2Banks = $clog2(NumBanks);
   localparam int unsigned BankW     = (NumBanks > 1) ? Log2Banks : 1;
   localparam int unsigned RowW      = $clog2(WordsPerBank);
   localparam int unsigned PtrW      = (NumPorts > 1) ? $clog2(NumPorts) : 1;

   // ------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------------
   if (NumPorts == 0) begin : g_chk_ports
      $error("tc_sram_banked: NumPorts must be >= 1");
   end
   if (NumBanks == 0 || (NumBanks & (NumBanks - 1)) != 0) begin : g_chk_banks
      $error("tc_sram_banked: NumBanks must be a power of 2");
   end
   if (WordsPerBank < 2 || (WordsPerBank & (WordsPerBank - 1)) != 0) begin : g_chk_words
      $error("tc_sram_banked: WordsPerBank must be a power of 2 and >= 2");
   end
   if (Latency == 0) begin : g_chk_lat
      $error("tc_sram_banked: Latency must be >= 1");
   end

   // Round-robin pick: lowest requesting index >= ptr, else lowest overall.
   // Returns {found, index}.
   function automatic logic [PtrW:0] f_pick(input logic [NumPorts-1:0] i_req,
                                            input logic [PtrW-1:0]     i_ptr);
      logic            l_found;
      logic [PtrW-1:0] l_idx;
      l_found = 1'b0;
      l_idx   = '0;
      for (int p = 0; p < NumPorts; p++) begin
         if (!l_found && i_req[p] && (p >= int'(i_ptr))) begin
            l_found = 1'b1;
            l_idx   = PtrW'(p);
         end
      end
      for (int p = 0; p < NumPorts; p++) begin
         if (!l_found && i_req[p]) begin
            l_found = 1'b1;
            l_idx   = PtrW'(p);
         end
      end
      return {l_found, l_idx};
   endfunction

   // ------------------------------------------------------------------------
   // Address decode. The mask/shift form also covers NumBanks == 1, where the
   // bank is always 0 and the row is the whole address.
   // ------------------------------------------------------------------------
   logic [NumPorts-1:0][BankW-1:0] w_bank;
   logic [NumPorts-1:0][RowW-1:0]  w_row;

   always_comb begin
      for (int p = 0; p < NumPorts; p++) begin
         w_bank[p] = BankW'(addr_i[p] & AddrWidth'(NumBanks - 1));
         w_row[p]  = RowW'(addr_i[p] >> Log2Banks);
      end
   end

   // ------------------------------------------------------------------------
   // Per-bank arbitration
   // ------------------------------------------------------------------------
   logic [PtrW-1:0]                     r_rr [NumBanks];
   logic [NumBanks-1:0][NumPorts-1:0]   w_breq;
   logic [NumBanks-1:0]                 w_win_vld;
   logic [NumBanks-1:0][PtrW-1:0]       w_win_idx;
   logic [NumPorts-1:0]                 w_gnt;
   logic [NumPorts-1:0]                 w_rd_acc;

   always_comb begin
      w_breq    = '0;
      w_win_vld = '0;
      w_win_idx = '0;
      for (int b = 0; b < NumBanks; b++) begin
         for (int p = 0; p < NumPorts; p++) begin
            w_breq[b][p] = req_i[p] && (w_bank[p] == BankW'(b));
         end
         {w_win_vld[b], w_win_idx[b]} = f_pick(w_breq[b], r_rr[b]);
      end
   end

   always_comb begin
      w_gnt    = '0;
      w_rd_acc = '0;
      for (int p = 0; p < NumPorts; p++) begin
         w_gnt[p]    = req_i[p] && w_win_vld[w_bank[p]] &&
                       (w_win_idx[w_bank[p]] == PtrW'(p));
         w_rd_acc[p] = w_gnt[p] && !we_i[p];
      end
   end

   assign gnt_o = w_gnt;

   // A winner is always accepted (grants only go to requestors), so the
   // pointer advances past it whenever the bank had any winner.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int b = 0; b < NumBanks; b++) begin
            r_rr[b] <= '0;
         end
      end else begin
         for (int b = 0; b < NumBanks; b++) begin
            if (w_win_vld[b]) begin
               r_rr[b] <= (w_win_idx[b] == PtrW'(NumPorts - 1)) ? '0
                                                                : w_win_idx[b] + 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Storage. Contents are intentionally not reset.
   // ------------------------------------------------------------------------
   logic [DataWidth-1:0] r_mem [NumBanks][WordsPerBank];

   always_ff @(posedge clk_i) begin
      for (int p = 0; p < NumPorts; p++) begin
         if (w_gnt[p] && we_i[p]) begin
            for (int j = 0; j < DataWidth; j++) begin
               if (be_i[p][j / ByteWidth]) begin
                  r_mem[w_bank[p]][w_row[p]][j] <= wdata_i[p][j];
               end
            end
         end
      end
   end

   // Read sees pre-write contents; the bank cannot be written by another
   // port in the same cycle because it has a single winner.
   logic [DataWidth-1:0] w_rd_data [NumPorts];

   always_comb begin
      for (int p = 0; p < NumPorts; p++) begin
         w_rd_data[p] = r_mem[w_bank[p]][w_row[p]];
      end
   end

`ifdef TC_SRAM_BANKED_PARITY_EN
   logic [BeWidth-1:0] r_par [NumBanks][WordsPerBank];
   logic [BeWidth-1:0] w_wpar [NumPorts];
   logic               w_rd_err [NumPorts];

   // Parity per byte; the last byte may be narrower than ByteWidth.
   always_comb begin
      for (int p = 0; p < NumPorts; p++) begin
         w_wpar[p] = '0;
         for (int j = 0; j < DataWidth; j++) begin
            w_wpar[p][j / ByteWidth] = w_wpar[p][j / ByteWidth] ^ wdata_i[p][j];
         end
      end
   end

   always_comb begin
      logic [BeWidth-1:0] l_rpar;
      for (int p = 0; p < NumPorts; p++) begin
         l_rpar = '0;
         for (int j = 0; j < DataWidth; j++) begin
            l_rpar[j / ByteWidth] = l_rpar[j / ByteWidth] ^ w_rd_data[p][j];
         end
         w_rd_err[p] = |(l_rpar ^ r_par[w_bank[p]][w_row[p]]);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int b = 0; b < NumBanks; b++) begin
            for (int r = 0; r < WordsPerBank; r++) begin
               r_par[b][r] <= '0;
            end
         end
      end else begin
         for (int p = 0; p < NumPorts; p++) begin
            if (w_gnt[p] && we_i[p]) begin
               for (int bb = 0; bb < BeWidth; bb++) begin
                  if (be_i[p][bb]) begin
                     r_par[w_bank[p]][w_row[p]][bb] <= w_wpar[p][bb];
                  end
               end
            end
         end
      end
   end
`endif

   // ------------------------------------------------------------------------
   // Read return pipeline, Latency stages per port. Stage data only loads
   // when a valid entry moves in, so the last stage holds the most recent
   // returned word while rvalid_o is low.
   // ------------------------------------------------------------------------
   logic [Latency-1:0]   r_pv [NumPorts];
   logic [DataWidth-1:0] r_pd [NumPorts][Latency];
   logic                 w_cv [NumPorts][Latency];
   logic [DataWidth-1:0] w_cd [NumPorts][Latency];

   always_comb begin
      for (int p = 0; p < NumPorts; p++) begin
         w_cv[p][0] = w_rd_acc[p];
         w_cd[p][0] = w_rd_data[p];
         for (int k = 1; k < Latency; k++) begin
            w_cv[p][k] = r_pv[p][k-1];
            w_cd[p][k] = r_pd[p][k-1];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int p = 0; p < NumPorts; p++) begin
            r_pv[p] <= '0;
            for (int k = 0; k < Latency; k++) begin
               r_pd[p][k] <= '0;
            end
         end
      end else begin
         for (int p = 0; p < NumPorts; p++) begin
            for (int k = 0; k < Latency; k++) begin
               r_pv[p][k] <= w_cv[p][k];
               if (w_cv[p][k]) begin
                  r_pd[p][k] <= w_cd[p][k];
               end
            end
         end
      end
   end

   always_comb begin
      for (int p = 0; p < NumPorts; p++) begin
         rvalid_o[p] = r_pv[p][Latency-1];
         rdata_o[p]  = r_pd[p][Latency-1];
      end
   end

`ifdef TC_SRAM_BANKED_PARITY_EN
   logic [Latency-1:0] r_pe [NumPorts];
   logic               w_ce [NumPorts][Latency];

   always_comb begin
      for (int p = 0; p < NumPorts; p++) begin
         w_ce[p][0] = w_rd_err[p];
         for (int k = 1; k < Latency; k++) begin
            w_ce[p][k] = r_pe[p][k-1];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int p = 0; p < NumPorts; p++) begin
            r_pe[p] <= '0;
         end
      end else begin
         for (int p = 0; p < NumPorts; p++) begin
            for (int k = 0; k < Latency; k++) begin
               if (w_cv[p][k]) begin
                  r_pe[p][k] <= w_ce[p][k];
               end
            end
         end
      end
   end

   always_comb begin
      for (int p = 0; p < NumPorts; p++) begin
         rerr_o[p] = r_pv[p][Latency-1] & r_pe[p][Latency-1];
      end
   end
`endif

endmodule

// File: tb/tb_tc_sram_banked.sv
// ----------------------------------------------------------------------------
// tb_tc_sram_banked
//
// Directed bench for tc_sram_banked. Instance dut uses Latency=1 and covers
// writes, byte enables, bank conflicts, round-robin order and parallel
// access. Instance dut3 uses Latency=3 and covers the deeper read pipeline
// and a reset in the middle of pending reads.
// ----------------------------------------------------------------------------
module tb_tc_sram_banked;

   logic clk;
   logic rst_n;
   logic rst3_n;

   // Latency = 1 instance
   logic [3:0]        req_a, we_a, gnt_a, rvalid_a;
   logic [3:0][9:0]   addr_a;
   logic [3:0][31:0]  wdata_a, rdata_a;
   logic [3:0][3:0]   be_a;

   // Latency = 3 instance
   logic [3:0]        req_b, we_b, gnt_b, rvalid_b;
   logic [3:0][9:0]   addr_b;
   logic [3:0][31:0]  wdata_b, rdata_b;
   logic [3:0][3:0]   be_b;

`ifdef TC_SRAM_BANKED_PARITY_EN
   logic [3:0]        rerr_a, rerr_b;
`endif

   int n_assert;
   int n_fail;

   tc_sram_banked #(.NumPorts(4), .NumBanks(4), .WordsPerBank(256),
                    .DataWidth(32), .ByteWidth(8), .Latency(1)) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .req_i    (req_a),
      .gnt_o    (gnt_a),
      .we_i     (we_a),
      .addr_i   (addr_a),
      .wdata_i  (wdata_a),
      .be_i     (be_a),
      .rvalid_o (rvalid_a),
      .rdata_o  (rdata_a)
`ifdef TC_SRAM_BANKED_PARITY_EN
      ,
      .rerr_o   (rerr_a)
`endif
   );

   tc_sram_banked #(.NumPorts(4), .NumBanks(4), .WordsPerBank(256),
                    .DataWidth(32), .ByteWidth(8), .Latency(3)) dut3 (
      .clk_i    (clk),
      .rst_ni   (rst3_n),
      .req_i    (req_b),
      .gnt_o    (gnt_b),
      .we_i     (we_b),
      .addr_i   (addr_b),
      .wdata_i  (wdata_b),
      .be_i     (be_b),
      .rvalid_o (rvalid_b),
      .rdata_o  (rdata_b)
`ifdef TC_SRAM_BANKED_PARITY_EN
      ,
      .rerr_o   (rerr_b)
`endif
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a();
      req_a = '0; we_a = '0; addr_a = '0; wdata_a = '0; be_a = '0;
   endtask

   task automatic idle_b();
      req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0; be_b = '0;
   endtask

   task automatic set_a(input int p, input logic we, input logic [9:0] addr,
                        input logic [31:0] data, input logic [3:0] be);
      req_a[p] = 1'b1; we_a[p] = we; addr_a[p] = addr;
      wdata_a[p] = data; be_a[p] = be;
   endtask

   task automatic clr_a(input int p);
      req_a[p] = 1'b0; we_a[p] = 1'b0;
   endtask

   task automatic set_b(input int p, input logic we, input logic [9:0] addr,
                        input logic [31:0] data, input logic [3:0] be);
      req_b[p] = 1'b1; we_b[p] = we; addr_b[p] = addr;
      wdata_b[p] = data; be_b[p] = be;
   endtask

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- safety timeout ----------------
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   // ---------------- directed sequence ----------------
   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      rst3_n   = 1'b0;
      idle_a();
      idle_b();
      #2;
      check("rst_rvalid_a", 64'(rvalid_a), 64'h0);
      check("rst_rdata_a0", 64'(rdata_a[0]), 64'h0);
      check("rst_rdata_a3", 64'(rdata_a[3]), 64'h0);
      check("rst_gnt_idle", 64'(gnt_a), 64'h0);
      check("rst_rvalid_b", 64'(rvalid_b), 64'h0);
      repeat (2) @(posedge clk);
      #3;
      rst_n  = 1'b1;
      rst3_n = 1'b1;
      step();

      // 1: full write then read back, Latency 1
      set_a(0, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF);
      #1 check("t1_wr_gnt", 64'(gnt_a), 64'h1);
      step();
      check("t1_wr_no_rvalid", 64'(rvalid_a), 64'h0);
      set_a(0, 1'b0, 10'h005, 32'h0, 4'h0);
      #1 check("t1_rd_gnt", 64'(gnt_a), 64'h1);
      step();
      check("t1_rvalid", 64'(rvalid_a), 64'h1);
      check("t1_rdata", 64'(rdata_a[0]), 64'hDEADBEEF);

      // 2: partial write of byte 1 only
      set_a(0, 1'b1, 10'h005, 32'h0000AA00, 4'b0010);
      #1 check("t2_wr_gnt", 64'(gnt_a), 64'h1);
      step();
      check("t2_wr_no_rvalid", 64'(rvalid_a), 64'h0);
      check("t2_rdata_hold", 64'(rdata_a[0]), 64'hDEADBEEF);
      set_a(0, 1'b0, 10'h005, 32'h0, 4'h0);
      step();
      check("t2_rvalid", 64'(rvalid_a), 64'h1);
      check("t2_rdata", 64'(rdata_a[0]), 64'hDEADAAEF);
      idle_a();
      step();
      check("t2_rvalid_single", 64'(rvalid_a), 64'h0);
      check("t2_rdata_held", 64'(rdata_a[0]), 64'hDEADAAEF);

      // reset between tests: outputs clear, array keeps its contents
      #2 rst_n = 1'b0;
      #1 check("mid_rst_rdata", 64'(rdata_a[0]), 64'h0);
      check("mid_rst_rvalid", 64'(rvalid_a), 64'h0);
      #2 rst_n = 1'b1;

      // 3: preload bank 1 from port 3 (leaves bank 1 pointer at 0)
      step();
      set_a(3, 1'b1, 10'h001, 32'h11111111, 4'hF);
      #1 check("t3_pre_gnt", 64'(gnt_a), 64'h8);
      step();
      set_a(3, 1'b1, 10'h009, 32'h99999999, 4'hF);
      step();
      set_a(3, 1'b1, 10'h00D, 32'hDDDDDDDD, 4'hF);
      step();
      // all four read bank 1; ungranted ports hold their request
      set_a(0, 1'b0, 10'h001, 32'h0, 4'h0);
      set_a(1, 1'b0, 10'h005, 32'h0, 4'h0);
      set_a(2, 1'b0, 10'h009, 32'h0, 4'h0);
      set_a(3, 1'b0, 10'h00D, 32'h0, 4'h0);
      #1 check("t3_gnt_c0", 64'(gnt_a), 64'h1);
      step();
      check("t3_rvalid_c1", 64'(rvalid_a), 64'h1);
      check("t3_rdata0", 64'(rdata_a[0]), 64'h11111111);
      clr_a(0);
      #1 check("t3_gnt_c1", 64'(gnt_a), 64'h2);
      step();
      check("t3_rvalid_c2", 64'(rvalid_a), 64'h2);
      check("t3_rdata1", 64'(rdata_a[1]), 64'hDEADAAEF);
      clr_a(1);
      #1 check("t3_gnt_c2", 64'(gnt_a), 64'h4);
      step();
      check("t3_rvalid_c3", 64'(rvalid_a), 64'h4);
      check("t3_rdata2", 64'(rdata_a[2]), 64'h99999999);
      clr_a(2);
      #1 check("t3_gnt_c3", 64'(gnt_a), 64'h8);
      step();
      check("t3_rvalid_c4", 64'(rvalid_a), 64'h8);
      check("t3_rdata3", 64'(rdata_a[3]), 64'hDDDDDDDD);
      check("t3_rdata0_hold", 64'(rdata_a[0]), 64'h11111111);
      idle_a();

      // 4: parallel writes then parallel reads to four distinct banks
      set_a(0, 1'b1, 10'h000, 32'hA0A0A0A0, 4'hF);
      set_a(1, 1'b1, 10'h001, 32'hB1B1B1B1, 4'hF);
      set_a(2, 1'b1, 10'h002, 32'hC2C2C2C2, 4'hF);
      set_a(3, 1'b1, 10'h003, 32'hD3D3D3D3, 4'hF);
      #1 check("t4_wr_gnt", 64'(gnt_a), 64'hF);
      step();
      for (int p = 0; p < 4; p++) begin
         set_a(p, 1'b0, 10'(p), 32'h0, 4'h0);
      end
      #1 check("t4_rd_gnt", 64'(gnt_a), 64'hF);
      step();
      check("t4_rvalid", 64'(rvalid_a), 64'hF);
      check("t4_rdata0", 64'(rdata_a[0]), 64'hA0A0A0A0);
      check("t4_rdata1", 64'(rdata_a[1]), 64'hB1B1B1B1);
      check("t4_rdata2", 64'(rdata_a[2]), 64'hC2C2C2C2);
      check("t4_rdata3", 64'(rdata_a[3]), 64'hD3D3D3D3);
      idle_a();

      // be = 0 write still takes the slot but changes nothing
      set_a(0, 1'b1, 10'h000, 32'hFFFFFFFF, 4'h0);
      #1 check("be0_gnt", 64'(gnt_a), 64'h1);
      step();
      set_a(0, 1'b0, 10'h000, 32'h0, 4'h0);
      step();
      check("be0_rdata", 64'(rdata_a[0]), 64'hA0A0A0A0);
      idle_a();

      // bank 2 pointer is 3 (port 2 won last): ports 0 and 2 contend, wrap
      // selects port 0 first
      set_a(0, 1'b1, 10'h002, 32'h22222222, 4'hF);
      set_a(2, 1'b1, 10'h006, 32'h66666666, 4'hF);
      #1 check("wrap_gnt_c0", 64'(gnt_a), 64'h1);
      step();
      clr_a(0);
      #1 check("wrap_gnt_c1", 64'(gnt_a), 64'h4);
      step();
      idle_a();

      // bank 1 pointer is 2 (port 1 won last): ports 0 and 3 contend,
      // port 3 is the first index >= 2
      set_a(0, 1'b0, 10'h001, 32'h0, 4'h0);
      set_a(3, 1'b0, 10'h00D, 32'h0, 4'h0);
      set_a(1, 1'b0, 10'h002, 32'h0, 4'h0);
      #1 check("rr_gnt_c0", 64'(gnt_a), 64'hA);
      step();
      check("rr_rvalid_c1", 64'(rvalid_a), 64'hA);
      check("rr_rdata3", 64'(rdata_a[3]), 64'hDDDDDDDD);
      check("rr_rdata1_new", 64'(rdata_a[1]), 64'h22222222);
      clr_a(3);
      clr_a(1);
      #1 check("rr_gnt_c1", 64'(gnt_a), 64'h1);
      step();
      check("rr_rvalid_c2", 64'(rvalid_a), 64'h1);
      check("rr_rdata0", 64'(rdata_a[0]), 64'hB1B1B1B1);
      idle_a();

`ifdef TC_SRAM_BANKED_PARITY_EN
      // 6: corrupt one stored bit of 0x010 (bank 0, row 4) behind the
      // parity bits, then read it and a clean word
      set_a(0, 1'b1, 10'h010, 32'h12345678, 4'hF);
      step();
      idle_a();
      dut.r_mem[0][4][0] = ~dut.r_mem[0][4][0];
      set_a(0, 1'b0, 10'h010, 32'h0, 4'h0);
      step();
      check("par_rvalid", 64'(rvalid_a), 64'h1);
      check("par_rdata", 64'(rdata_a[0]), 64'h12345679);
      check("par_rerr", 64'(rerr_a), 64'h1);
      set_a(0, 1'b0, 10'h000, 32'h0, 4'h0);
      step();
      check("par_clean_rerr", 64'(rerr_a), 64'h0);
      check("par_clean_rdata", 64'(rdata_a[0]), 64'hA0A0A0A0);
      idle_a();
`endif

      // 5: Latency 3 on port 2
      set_b(2, 1'b1, 10'h020, 32'h000000A1, 4'hF);
      #1 check("l3_wr_gnt", 64'(gnt_b), 64'h4);
      step();
      set_b(2, 1'b1, 10'h021, 32'h000000A2, 4'hF);
      step();
      set_b(2, 1'b1, 10'h022, 32'h000000A3, 4'hF);
      step();
      check("l3_wr_no_rvalid", 64'(rvalid_b), 64'h0);
      set_b(2, 1'b0, 10'h020, 32'h0, 4'h0);
      #1 check("l3_rd_gnt", 64'(gnt_b), 64'h4);
      step();                                    // first accept done
      check("l3_rvalid_e0", 64'(rvalid_b), 64'h0);
      set_b(2, 1'b0, 10'h021, 32'h0, 4'h0);
      step();
      check("l3_rvalid_e1", 64'(rvalid_b), 64'h0);
      set_b(2, 1'b0, 10'h022, 32'h0, 4'h0);
      step();                                    // third accept done
      check("l3_rvalid_1st", 64'(rvalid_b), 64'h4);
      check("l3_rdata_1st", 64'(rdata_b[2]), 64'hA1);
      idle_b();
      step();
      check("l3_rvalid_2nd", 64'(rvalid_b), 64'h4);
      check("l3_rdata_2nd", 64'(rdata_b[2]), 64'hA2);
      // third read is still in flight: reset discards it
      #2 rst3_n = 1'b0;
      #1 check("l3_rst_rvalid", 64'(rvalid_b), 64'h0);
      check("l3_rst_rdata", 64'(rdata_b[2]), 64'h0);
      #2 rst3_n = 1'b1;
      step();
      check("l3_post_rst_e4", 64'(rvalid_b), 64'h0);
      step();
      check("l3_post_rst_e5", 64'(rvalid_b), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/tc_sram_banked.md
Name: tc_sram_banked

Overview:
Parametrised multi-port, multi-bank functional SRAM, word-interleaved across NumBanks single-ported banks, with request/grant arbitration.
- Any of NumPorts requestors may target any bank each cycle.
- Per-bank round-robin arbitration resolves conflicts; one access per bank per cycle.
- Read data returns with a valid strobe after a fixed, configurable latency.
- Replaces fixed-port tc_sram instances inside tile-level L1 scratchpads, where core/DMA ports share banks.

Parameters:
NumPorts, 4, number of requestor ports (>=1)
NumBanks, 4, number of banks (power of 2, >=1)
WordsPerBank, 256, words per bank (power of 2, >=2)
DataWidth, 32, data word width
ByteWidth, 8, byte width for byte enables
Latency, 1, read latency in cycles from accept to rvalid_o (>=1)
AddrWidth, $clog2(NumBanks*WordsPerBank), derived, do not override
BeWidth, ceil(DataWidth/ByteWidth), derived, do not override

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous reset, active low
req_i  input  NumPorts  per-port request
gnt_o  output  NumPorts  per-port grant, combinational from req_i/addr_i and arbiter state
we_i  input  NumPorts  per-port write enable (1 = write)
addr_i  input  NumPorts x AddrWidth  per-port word address
wdata_i  input  NumPorts x DataWidth  per-port write data
be_i  input  NumPorts x BeWidth  per-port byte enables
rvalid_o  output  NumPorts  per-port read-data valid
rdata_o  output  NumPorts x DataWidth  per-port read data
Reset rst_ni, asynchronous, active-low; clock clk_i.

Behaviour:
Address decode:
- Bank = addr_i[$clog2(NumBanks)-1:0]; row = the remaining upper bits.
- NumBanks == 1: bank 0 always; row = full address.

Arbitration and accept:
- Each bank has a round-robin arbiter with pointer rr_q (reset 0).
- Among ports requesting the bank, the lowest index >= rr_q wins; if none, wrap to the lowest index overall.
- gnt_o[i] = 1 only when port i wins its target bank; gnt_o[i] = 0 whenever req_i[i] = 0.
- At most one grant per bank per cycle; ports targeting different banks are granted in parallel.
- Accept = req_i & gnt_o. rr_q of that bank <= winner+1 (mod NumPorts) on accept; unchanged if the bank is idle.
- Non-granted requestors hold req/addr/we/wdata/be stable until granted; no request is dropped.
- Starvation bound: a held request is granted within NumPorts cycles.

Writes:
- On an accepted write, at the clock edge, bits of byte b update only where be_i[i][b] = 1.
- be = 0 is a no-op write that still consumes the bank slot.
- Writes produce no rvalid.

Reads:
- An accepted read samples the bank array combinationally in the accept cycle; the value is the pre-write contents, and no other write to that bank can occur that cycle.
- The value passes through a Latency-deep pipeline per port.
- rvalid_o[i] = 1 exactly Latency cycles after the accept, for exactly one cycle per accepted read.
- Back-to-back accepts yield back-to-back rvalid in order.
- rdata_o[i] holds its last valid value when rvalid_o[i] = 0.

Reset:
- rvalid_o = 0, rdata_o = 0, all rr_q = 0.
- In-flight read pipeline entries are discarded (reset mid-operation loses pending reads).
- Array contents are not reset; in simulation they are 'x until written.

Boundaries:
- addr_i is always in range, because all sizes are powers of 2.
- Parameter checks fire elaboration assertions: NumBanks/WordsPerBank not powers of 2, Latency = 0, NumPorts = 0.

Optional Feature:
Macro: TC_SRAM_BANKED_PARITY_EN.
- Defined:
  - Each byte stores one extra even-parity bit, computed on write from wdata and updated only for enabled bytes.
  - Extra output port rerr_o [NumPorts], asserted with rvalid_o when any byte's stored parity mismatches the recomputed parity of the read data.
  - rerr_o resets to 0.
  - Parity bits are reset to 0 alongside an 'x array.
- Not defined:
  - No parity storage and no rerr_o port.
  - Behaviour otherwise identical.

Test Plan:
1. Config NumPorts=4, NumBanks=4, Latency=1. Port0 writes addr 0x005 data 0xDEADBEEF be=4'hF, then reads 0x005 -> gnt same cycle; rvalid_o[0] one cycle after the read accept with rdata 0xDEADBEEF.
2. Partial write: be=4'b0010 data 0x0000AA00 to 0x005 after test 1, then read -> rdata 0xDEADAAEF.
3. Conflict: ports 0-3 all request reads to bank 1 (addrs 0x001, 0x005, 0x009, 0x00D) held continuously -> grants in order 0,1,2,3 over 4 cycles, one per cycle; each rvalid one cycle after its grant with the correct data.
4. Parallel: ports 0-3 read addrs 0x000, 0x001, 0x002, 0x003 (distinct banks) -> all gnt_o = 4'hF in one cycle; all rvalid_o = 4'hF next cycle.
5. Latency=3: issue reads on 3 consecutive cycles on port 2 -> rvalid_o[2] high for cycles 3, 4, 5 after the first accept, data in order; assert rst_ni mid-stream -> rvalid_o drops to 0 immediately and no further rvalid appears.
6. With TC_SRAM_BANKED_PARITY_EN: force-flip one stored data bit via backdoor at 0x010, then read -> rerr_o asserted with rvalid_o; a clean address read -> rerr_o = 0.
